wb_regfile_sequencer: RTL and testbench

- Write-back stage: consumes the 76-bit bundle produced by mem_wb_pipeline_reg and commits it to a 16 x 32 architectural register file with a single write port.
- Bundle may request two writes: the load/ALU result, and the base-register update from pre/post-indexed load/store. Those two writes are serialised over two cycles, and the upstream stage is stalled during the second.
- Also provides two combinational read ports with write bypass, and a registered PC-redirect pulse for writes to r15.

---
 rtl/wb_regfile_sequencer.sv | 146 ++++++++++++++
 tb/tb_wb_regfile_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_regfile_sequencer: write-back sequencer committing up to two writes   |
// | per bundle into a bypassed 16 x 32 register file. Revision: 1.0          |
// +--------------------------------------------------------------------------+
module wb_regfile_sequencer #(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 32,
   parameter int PC_REG   = 15
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*DATA_W+11:0]  in_bundle,
   input  logic [3:0]            rd_addr_a,
   output logic [DATA_W-1:0]     rd_data_a,
   input  logic [3:0]            rd_addr_b,
   output logic [DATA_W-1:0]     rd_data_b,
   output logic                  rf_we,
   output logic [3:0]            rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic                  pc_redirect_valid,
   output logic [DATA_W-1:0]     pc_redirect_target
);

   localparam int         BUNDLE_W = 2 * DATA_W + 12;
   localparam logic [3:0] PC_ADDR  = 4'(PC_REG);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BASE = 1'b1
   } state_t;

   logic [3:0]        ctrl_wb;
   logic [3:0]        addr_wb;
   logic [3:0]        addr_upd;
   logic [DATA_W-1:0] base_data;
   logic [DATA_W-1:0] wb_data;
   logic              wb_en;
   logic              base_en;
   logic              byte_en;
   logic              accept;
   logic              unused_ctrl;

   state_t            state_q, state_d;
   logic [3:0]        base_addr_q, base_addr_d;
   logic [DATA_W-1:0] base_data_q, base_data_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              pc_valid_q, pc_valid_d;
   logic [DATA_W-1:0] pc_target_q, pc_target_d;

   assign ctrl_wb     = in_bundle[BUNDLE_W-1 -: 4];
   assign addr_wb     = in_bundle[BUNDLE_W-5 -: 4];
   assign addr_upd    = in_bundle[BUNDLE_W-9 -: 4];
   assign base_data   = in_bundle[2*DATA_W-1 -: DATA_W];
   assign wb_data     = in_bundle[DATA_W-1:0];
   assign wb_en       = ctrl_wb[3];
   assign base_en     = ctrl_wb[2];
   assign byte_en     = ctrl_wb[1];
   assign unused_ctrl = ctrl_wb[0];

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      base_addr_d = base_addr_q;
      base_data_d = base_data_q;
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (wb_en) begin
                  rf_we    = 1'b1;
                  rf_waddr = addr_wb;
                  rf_wdata = byte_en ? {{(DATA_W-8){1'b0}}, wb_data[7:0]} : wb_data;
                  // Same-address base update is dropped: the loaded value wins.
                  if (base_en && (addr_upd != addr_wb)) begin
                     state_d     = BASE;
                     base_addr_d = addr_upd;
                     base_data_d = base_data;
                  end
               end else if (base_en) begin
                  rf_we    = 1'b1;
                  rf_waddr = addr_upd;
                  rf_wdata = base_data;
               end
            end
         end
         BASE: begin
            rf_we    = 1'b1;
            rf_waddr = base_addr_q;
            rf_wdata = base_data_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!reset_n) begin
         rf_we    = 1'b0;
         rf_waddr = '0;
         rf_wdata = '0;
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (rf_we) begin
         regs_d[rf_waddr] = rf_wdata;
      end
      pc_valid_d  = rf_we && (rf_waddr == PC_ADDR);
      pc_target_d = pc_valid_d ? rf_wdata : pc_target_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         base_addr_q <= '0;
         base_data_q <= '0;
         pc_valid_q  <= 1'b0;
         pc_target_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         base_addr_q <= base_addr_d;
         base_data_q <= base_data_d;
         pc_valid_q  <= pc_valid_d;
         pc_target_q <= pc_target_d;
         regs_q      <= regs_d;
      end
   end

   assign pc_redirect_valid  = pc_valid_q;
   assign pc_redirect_target = pc_target_q;

   // Reads see the write that lands at the coming edge.
   assign rd_data_a = (rf_we && (rf_waddr == rd_addr_a)) ? rf_wdata : regs_q[rd_addr_a];
   assign rd_data_b = (rf_we && (rf_waddr == rd_addr_b)) ? rf_wdata : regs_q[rd_addr_b];

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_sequencer.sv
`default_nettype none
// Randomised and directed bench for wb_regfile_sequencer with a
// write-list reference model of the write-back sequencing rules.
module tb_wb_regfile_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [75:0] in_bundle;
   logic [3:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rd_data_a, rd_data_b;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect_target;

   int n_checks = 0;
   int n_fail   = 0;

   wb_regfile_sequencer dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_bundle          (in_bundle),
      .rd_addr_a          (rd_addr_a),
      .rd_data_a          (rd_data_a),
      .rd_addr_b          (rd_addr_b),
      .rd_data_b          (rd_data_b),
      .rf_we              (rf_we),
      .rf_waddr           (rf_waddr),
      .rf_wdata           (rf_wdata),
      .pc_redirect_valid  (pc_redirect_valid),
      .pc_redirect_target (pc_redirect_target)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0]  a;
      logic [31:0] d;
   } wr_t;

   function automatic logic [75:0] mk(input logic [3:0] c, input logic [3:0] awb,
                                      input logic [3:0] aru, input logic [31:0] base,
                                      input logic [31:0] wb);
      return {c, awb, aru, base, wb};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_bundle = '0;
      reset_n   = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      in_bundle = mk(4'b1000, 4'd1, 4'd0, 32'h0, 32'h1234);
      #2;
      n_checks++;
      if (rf_we !== 1'b0) begin
         n_fail++; $display("FAIL reset_we: got %b want 0", rf_we);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready);
      end
      n_checks++;
      if (rf_waddr !== 4'd0 || rf_wdata !== 32'd0) begin
         n_fail++; $display("FAIL reset_wport: got %h/%h want 0/0", rf_waddr, rf_wdata);
      end
      tick();
      in_valid = 1'b0;
      reset_n  = 1'b1;
      #1;
      for (int i = 0; i < 16; i++) begin
         rd_addr_a = 4'(i);
         rd_addr_b = 4'(15 - i);
         #1;
         n_checks++;
         if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs r%0d: got a=%h b=%h want 0", i, rd_data_a, rd_data_b);
         end
      end
      n_checks++;
      if (pc_redirect_valid !== 1'b0 || pc_redirect_target !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_pc: got %b/%h want 0/0", pc_redirect_valid, pc_redirect_target);
      end
   endtask

   task automatic test_single_write();
      rd_addr_a = 4'd4;
      in_valid  = 1'b1;
      in_bundle = mk(4'b1000, 4'd4, 4'd0, 32'h0, 32'h00001111);
      #1;
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 32'h00001111) begin
         n_fail++; $display("FAIL single_wport: got %b/%h/%h want 1/4/00001111", rf_we, rf_waddr, rf_wdata);
      end
      n_checks++;
      if (rd_data_a !== 32'h00001111) begin
         n_fail++; $display("FAIL single_bypass: got %h want 00001111", rd_data_a);
      end
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (rd_data_a !== 32'h00001111 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_commit: got %h rdy %b want 00001111 rdy 1", rd_data_a, in_ready);
      end
      n_checks++;
      if (rf_we !== 1'b0 || rf_waddr !== 4'd0 || rf_wdata !== 32'd0) begin
         n_fail++; $display("FAIL idle_wport: got %b/%h/%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_byte();
      rd_addr_a = 4'd4;
      in_valid  = 1'b1;
      in_bundle = mk(4'b1010, 4'd4, 4'd0, 32'h0, 32'h98765432);
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (rd_data_a !== 32'h00000032) begin
         n_fail++; $display("FAIL byte_zext: got %h want 00000032", rd_data_a);
      end
   endtask

   task automatic test_double_write();
      in_valid  = 1'b1;
      in_bundle = mk(4'b1100, 4'd4, 4'd9, 32'h10293847, 32'h00001111);
      #1;
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL dbl_c1: got we %b addr %h rdy %b want 1/4/1", rf_we, rf_waddr, in_ready);
      end
      tick();
      in_bundle = mk(4'b1000, 4'd3, 4'd0, 32'h0, 32'h5);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || rf_waddr !== 4'd9 || rf_wdata !== 32'h10293847) begin
         n_fail++; $display("FAIL dbl_c2: got rdy %b addr %h data %h want 0/9/10293847", in_ready, rf_waddr, rf_wdata);
      end
      tick();
      rd_addr_a = 4'd9;
      rd_addr_b = 4'd4;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 32'h5) begin
         n_fail++; $display("FAIL dbl_c3: got rdy %b addr %h data %h want 1/3/5", in_ready, rf_waddr, rf_wdata);
      end
      n_checks++;
      if (rd_data_a !== 32'h10293847 || rd_data_b !== 32'h00001111) begin
         n_fail++; $display("FAIL dbl_regs: got r9 %h r4 %h want 10293847/00001111", rd_data_a, rd_data_b);
      end
      tick();
      in_valid  = 1'b0;
      rd_addr_a = 4'd3;
      #1;
      n_checks++;
      if (rd_data_a !== 32'h5 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL dbl_second: got r3 %h rdy %b want 5/1", rd_data_a, in_ready);
      end
   endtask

   task automatic test_collision();
      in_valid  = 1'b1;
      in_bundle = mk(4'b1100, 4'd7, 4'd7, 32'hBBBB0000, 32'hAAAA0000);
      rd_addr_a = 4'd7;
      #1;
      n_checks++;
      if (rf_waddr !== 4'd7 || rf_wdata !== 32'hAAAA0000) begin
         n_fail++; $display("FAIL coll_wport: got %h/%h want 7/AAAA0000", rf_waddr, rf_wdata);
      end
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || rf_we !== 1'b0 || rd_data_a !== 32'hAAAA0000) begin
         n_fail++; $display("FAIL coll_single: got rdy %b we %b r7 %h want 1/0/AAAA0000", in_ready, rf_we, rd_data_a);
      end
   endtask

   task automatic test_bypass_pc();
      rd_addr_a = 4'd15;
      in_valid  = 1'b1;
      in_bundle = mk(4'b1000, 4'd15, 4'd0, 32'h0, 32'h00000100);
      #1;
      n_checks++;
      if (rd_data_a !== 32'h100 || pc_redirect_valid !== 1'b0) begin
         n_fail++; $display("FAIL pc_bypass: got %h pcv %b want 100/0", rd_data_a, pc_redirect_valid);
      end
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 32'h100) begin
         n_fail++; $display("FAIL pc_pulse: got %b/%h want 1/100", pc_redirect_valid, pc_redirect_target);
      end
      tick();
      n_checks++;
      if (pc_redirect_valid !== 1'b0 || pc_redirect_target !== 32'h100) begin
         n_fail++; $display("FAIL pc_hold: got %b/%h want 0/100", pc_redirect_valid, pc_redirect_target);
      end
   endtask

   task automatic test_reset_mid_base();
      in_valid  = 1'b1;
      in_bundle = mk(4'b1100, 4'd2, 4'd5, 32'h0000DEAD, 32'h0000BEEF);
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_in_base: got rdy %b want 0", in_ready);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || rf_we !== 1'b0) begin
         n_fail++; $display("FAIL mid_async: got rdy %b we %b want 1/0", in_ready, rf_we);
      end
      tick();
      reset_n   = 1'b1;
      rd_addr_a = 4'd5;
      rd_addr_b = 4'd2;
      #1;
      n_checks++;
      if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0 || pc_redirect_target !== 32'd0) begin
         n_fail++; $display("FAIL mid_cleared: got r5 %h r2 %h pct %h want 0/0/0", rd_data_a, rd_data_b, pc_redirect_target);
      end
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || rf_we !== 1'b0 || rd_data_a !== 32'd0) begin
         n_fail++; $display("FAIL mid_dropped: got rdy %b we %b r5 %h want 1/0/0", in_ready, rf_we, rd_data_a);
      end
   endtask

   task automatic test_random();
      logic [31:0] m_rf [16];
      wr_t         pend [$];
      wr_t         cur;
      logic        cur_v, exp_rdy, exp_pcv;
      logic [31:0] exp_pct, exp_a, exp_b, wbv;
      logic [3:0]  c, awb, aru;
      logic [31:0] base, wb;
      do_reset();
      foreach (m_rf[i]) m_rf[i] = 32'd0;
      exp_pct = 32'd0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         c    = 4'($urandom_range(0, 15));
         awb  = 4'($urandom_range(0, 15));
         aru  = ($urandom_range(0, 3) == 0) ? awb : 4'($urandom_range(0, 15));
         base = $urandom;
         wb   = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_bundle = mk(c, awb, aru, base, wb);
         rd_addr_a = ($urandom_range(0, 1) == 0) ? awb : 4'($urandom_range(0, 15));
         rd_addr_b = ($urandom_range(0, 1) == 0) ? aru : 4'($urandom_range(0, 15));
         // Model: an accepted bundle expands into an ordered list of writes,
         // one retired per cycle; new bundles wait until the list drains.
         cur_v   = 1'b0;
         cur     = '0;
         exp_rdy = (pend.size() == 0);
         if (!exp_rdy) begin
            cur   = pend.pop_front();
            cur_v = 1'b1;
         end else if (in_valid) begin
            wr_t lst [$];
            wbv = c[1] ? (wb & 32'hFF) : wb;
            if (c[3]) lst.push_back('{a: awb, d: wbv});
            if (c[2] && !(c[3] && aru == awb)) lst.push_back('{a: aru, d: base});
            if (lst.size() > 0) begin
               cur   = lst.pop_front();
               cur_v = 1'b1;
               pend  = lst;
            end
         end
         exp_a = (cur_v && cur.a == rd_addr_a) ? cur.d : m_rf[rd_addr_a];
         exp_b = (cur_v && cur.a == rd_addr_b) ? cur.d : m_rf[rd_addr_b];
         #1;
         n_checks++;
         if (in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy);
         end
         n_checks++;
         if (rf_we !== cur_v || rf_waddr !== cur.a || rf_wdata !== cur.d) begin
            n_fail++; $display("FAIL rnd_wport c%0d: got %b/%h/%h want %b/%h/%h",
                               cyc, rf_we, rf_waddr, rf_wdata, cur_v, cur.a, cur.d);
         end
         n_checks++;
         if (rd_data_a !== exp_a || rd_data_b !== exp_b) begin
            n_fail++; $display("FAIL rnd_read c%0d: got %h/%h want %h/%h", cyc, rd_data_a, rd_data_b, exp_a, exp_b);
         end
         if (cur_v) m_rf[cur.a] = cur.d;
         exp_pcv = cur_v && (cur.a == 4'd15);
         if (exp_pcv) exp_pct = cur.d;
         tick();
         n_checks++;
         if (pc_redirect_valid !== exp_pcv || pc_redirect_target !== exp_pct) begin
            n_fail++; $display("FAIL rnd_pc c%0d: got %b/%h want %b/%h",
                               cyc, pc_redirect_valid, pc_redirect_target, exp_pcv, exp_pct);
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_bundle = '0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      #1;
      test_reset();
      test_single_write();
      test_byte();
      test_double_write();
      test_collision();
      test_bypass_pc();
      test_reset_mid_base();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
